// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ADDR_LSB = 2;

    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

    // Keeps a one-word array from collapsing to a zero-width index.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with registered read; a write returns the new word on rdata.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int IDX_W      = idx_width(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
            rdata_q    <= wdata;
        end else begin
            rdata_q    <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one request at a time, fixed access latency, held response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);

    localparam int CNT_W     = cnt_width(LATENCY);
    localparam int IDX_W     = ADDR_WIDTH - ADDR_LSB;
    localparam int RAM_IDX_W = idx_width(MEM_WORDS);

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be >= 1");
    end

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic                  resp_valid_q, resp_valid_d;

    logic                  in_range;
    logic                  access;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  addr_lsb_unused;

    assign addr_lsb_unused = ^req_addr[ADDR_LSB-1:0];

    assign in_range = (idx_q < IDX_W'(MEM_WORDS));
    assign access   = (state_q == WAIT) && (cnt_q == '0);
    // Out-of-range writes must not alias onto the truncated RAM index.
    assign ram_we   = access && write_q && in_range;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = req_addr[ADDR_WIDTH-1:ADDR_LSB];
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    err_d        = !in_range;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // The RAM keeps reading the latched index, so its output holds steady through RESP.
    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .IDX_W      (RAM_IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .idx   (idx_q[RAM_IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = err_q;
    assign resp_rdata = (resp_valid_q && !err_q) ? ram_rdata : '0;

endmodule
